// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, registers IMem data into ir for decode.
// Optional FETCH_FLUSH_EN adds a FLUSH state after redirect for a registered IMem.
module imem_fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_MAX   = 16'hFFFF,
  parameter logic [5:0]  J_OPCODE = 6'b000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [31:0] Instruction,
  output logic [15:0] PC,
  output logic [31:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t      st, st_nxt;
  logic [15:0] pc_nxt, ir_pc_nxt, seq_pc;
  logic [31:0] ir_nxt, cnt_nxt;
  logic        ir_valid_nxt;

  // Decode handshake: ir is consumed on an edge where ir_valid=1 and stall=0;
  // while stall=1 the fetch register and PC hold, so nothing is lost or repeated.
  assign state  = st;
  assign seq_pc = (PC == PC_MAX) ? RESET_PC : PC + 16'd1;

  always_comb begin
    st_nxt       = st;
    pc_nxt       = PC;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid;
    cnt_nxt      = fetch_cnt;
    case (st)
      IDLE: begin
        ir_valid_nxt = 1'b0;
        st_nxt       = RUN;
      end
      RUN, STALL: begin
        if (redirect) begin
          pc_nxt       = redirect_pc;
          ir_nxt       = 32'h0;
          ir_valid_nxt = 1'b0;
`ifdef FETCH_FLUSH_EN
          st_nxt       = FLUSH;
`else
          st_nxt       = RUN;
`endif
        end else if (stall) begin
          st_nxt = STALL;
        end else begin
          ir_nxt       = Instruction;
          ir_pc_nxt    = PC;
          ir_valid_nxt = 1'b1;
          cnt_nxt      = fetch_cnt + 32'd1;
          pc_nxt       = (Instruction[31:26] == J_OPCODE) ? Instruction[15:0] : seq_pc;
          st_nxt       = RUN;
        end
      end
      FLUSH: begin
        // Memory output is not yet valid for the target; stall is ignored here.
        ir_valid_nxt = 1'b0;
        if (redirect) begin
          pc_nxt = redirect_pc;
          ir_nxt = 32'h0;
          st_nxt = FLUSH;
        end else begin
          st_nxt = RUN;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      PC        <= RESET_PC;
      ir        <= 32'h0;
      ir_pc     <= 16'h0;
      ir_valid  <= 1'b0;
      fetch_cnt <= 32'h0;
    end else begin
      st        <= st_nxt;
      PC        <= pc_nxt;
      ir        <= ir_nxt;
      ir_pc     <= ir_pc_nxt;
      ir_valid  <= ir_valid_nxt;
      fetch_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: vector table plus hand sequences for redirect,
// jump, reset-override and PC_MAX wrap (second instance with PC_MAX=3).
module tb_imem_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [31:0] instruction;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic [31:0] fetch_cnt;
  logic [1:0]  state;

  logic        rst2 = 1'b1;
  logic [31:0] instruction2;
  logic [15:0] pc2, ir_pc2;
  logic [31:0] ir2, fetch_cnt2;
  logic        ir_valid2;
  logic [1:0]  state2;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [15:0] a);
    case (a)
      16'd0:   return 32'h0000_0000;
      16'd1:   return 32'hC821_0005;
      16'd26:  return 32'h0400_0000;
      default: return {16'hE000, a};
    endcase
  endfunction

  assign instruction  = imem(pc);
  assign instruction2 = imem(pc2);

  imem_fetch_sequencer u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .Instruction(instruction), .PC(pc), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .fetch_cnt(fetch_cnt), .state(state)
  );

  imem_fetch_sequencer #(.PC_MAX(16'd3)) u_dut_max (
    .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0),
    .Instruction(instruction2), .PC(pc2), .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2),
    .fetch_cnt(fetch_cnt2), .state(state2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic [31:0] cnt;
    logic [1:0]  state;
  } vec_t;

  vec_t        tbl[9];
  vec_t        vq[$];
  logic [15:0] exp_q[$];

`ifdef FETCH_FLUSH_EN
  localparam logic [1:0] RD_ST = 2'd3;
`else
  localparam logic [1:0] RD_ST = 2'd1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d.%s actual=%h expected=%h", step_no, name, act, exp);
    end
  endtask

  // Drive one edge's inputs, queue the expectation, compare just after the edge.
  task automatic step(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                      input logic [15:0] epc, input logic [31:0] eir, input logic [15:0] eirpc,
                      input logic ev, input logic [31:0] ecnt, input logic [1:0] est);
    vec_t v;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    v = '{r, s, rd, rpc, epc, eir, eirpc, ev, ecnt, est};
    vq.push_back(v);
    @(posedge clk); #1;
    v = vq.pop_front();
    chk("pc", {16'h0, pc}, {16'h0, v.pc});
    chk("ir", ir, v.ir);
    chk("ir_pc", {16'h0, ir_pc}, {16'h0, v.ir_pc});
    chk("ir_valid", {31'h0, ir_valid}, {31'h0, v.ir_valid});
    chk("fetch_cnt", fetch_cnt, v.cnt);
    chk("state", {30'h0, state}, {30'h0, v.state});
    step_no++;
  endtask

  initial begin
    //          rst   stall redir rpc     pc      ir            ir_pc   vld   cnt    st
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0, 16'd0, 32'h0,        16'd0, 1'b0, 32'd0, 2'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0, 16'd0, 32'h0,        16'd0, 1'b0, 32'd0, 2'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 16'h0, 16'd0, 32'h0,        16'd0, 1'b0, 32'd0, 2'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0, 16'd1, 32'h0,        16'd0, 1'b1, 32'd1, 2'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0, 16'd2, 32'hC8210005, 16'd1, 1'b1, 32'd2, 2'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0, 16'd3, 32'hE0000002, 16'd2, 1'b1, 32'd3, 2'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0, 16'd3, 32'hE0000002, 16'd2, 1'b1, 32'd3, 2'd2};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h0, 16'd3, 32'hE0000002, 16'd2, 1'b1, 32'd3, 2'd2};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 16'h0, 16'd4, 32'hE0000003, 16'd3, 1'b1, 32'd4, 2'd1};
    for (int i = 0; i < 9; i++)
      step(tbl[i].rst, tbl[i].stall, tbl[i].redirect, tbl[i].rpc, tbl[i].pc, tbl[i].ir,
           tbl[i].ir_pc, tbl[i].ir_valid, tbl[i].cnt, tbl[i].state);

    // redirect to the jump at 26; jump delivered valid, target 0 fetched next
    step(1'b0, 1'b0, 1'b1, 16'd26, 16'd26, 32'h0, 16'd3, 1'b0, 32'd4, RD_ST);
`ifdef FETCH_FLUSH_EN
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'd26, 32'h0, 16'd3, 1'b0, 32'd4, 2'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'h04000000, 16'd26, 1'b1, 32'd5, 2'd1);
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'd1, 32'h0, 16'd0, 1'b1, 32'd6, 2'd1);

    // redirect beats stall on the same edge
    step(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0011, 32'h0, 16'd0, 1'b0, 32'd6, RD_ST);
`ifdef FETCH_FLUSH_EN
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'h0011, 32'h0, 16'd0, 1'b0, 32'd6, 2'd1);
`endif
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'h0012, 32'hE0000011, 16'h0011, 1'b1, 32'd7, 2'd1);

    // reset during STALL
    step(1'b0, 1'b1, 1'b0, 16'd0, 16'h0012, 32'hE0000011, 16'h0011, 1'b1, 32'd7, 2'd2);
    step(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 32'h0, 16'd0, 1'b0, 32'd0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0, 16'd0, 1'b0, 32'd0, 2'd1);
`ifdef FETCH_FLUSH_EN
    // redirect inside FLUSH reloads the target; reset during FLUSH
    step(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0020, 32'h0, 16'd0, 1'b0, 32'd0, 2'd3);
    step(1'b0, 1'b0, 1'b1, 16'h0030, 16'h0030, 32'h0, 16'd0, 1'b0, 32'd0, 2'd3);
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0, 16'd0, 1'b0, 32'd0, 2'd0);
`else
    // reset overrides a simultaneous redirect and stall
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'd1, 32'h0, 16'd0, 1'b1, 32'd1, 2'd1);
    step(1'b1, 1'b1, 1'b1, 16'h0040, 16'd0, 32'h0, 16'd0, 1'b0, 32'd0, 2'd0);
`endif
    rst = 1'b0;

    // PC_MAX=3 wrap: delivered ir_pc sequence 0,1,2,3,0,1
    exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd2);
    exp_q.push_back(16'd3); exp_q.push_back(16'd0); exp_q.push_back(16'd1);
    rst2 = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (ir_valid2) chk("wrap_ir_pc", {16'h0, ir_pc2}, {16'h0, exp_q.pop_front()});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_timeout actual=%0d expected=0 outstanding", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
